// File: rtl/instr_mem_sink.sv
// Instruction memory filled by a streaming loader, then served to a core fetch port.
// The loader phase ends on the first idle cycle. After that the memory is read-only and fetches are answered.
module instr_mem_sink #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  output logic        ready,
  output logic [31:0] start_pc,
  output logic [15:0] word_count,
  output logic        load_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;
  typedef enum logic [1:0] {SelZero, SelNop, SelRam} rd_sel_e;

  state_e     state_q, state_d;
  rd_sel_e    rd_sel_q, rd_sel_d;
  logic       ready_q, ready_d;
  logic       if_valid_q, if_valid_d;
  logic       load_err_q, load_err_d;
  logic [15:0] word_count_q, word_count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  logic            load_phase, wr_ok, wr_accept, wr_reject;
  logic            rd_fire, rd_ok;
  logic [IdxW-1:0] wr_idx, rd_idx;

  assign load_phase = (state_q != StRun);
  assign wr_idx     = addr[IdxW+1:2];
  assign rd_idx     = if_addr[IdxW+1:2];
  assign wr_ok      = (addr[1:0] == 2'b00) && (addr[31:IdxW+2] == '0);
  assign rd_ok      = (if_addr[1:0] == 2'b00) && (if_addr[31:IdxW+2] == '0);
  assign wr_accept  = we && load_phase && wr_ok;
  // Writes are rejected outright once running, regardless of the address.
  assign wr_reject  = we && !(load_phase && wr_ok);
  assign rd_fire    = if_req && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (we) state_d = StLoad;
      StLoad:  if (!we) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StRun);

    word_count_d = word_count_q;
    if (wr_accept && (word_count_q != 16'hFFFF)) word_count_d = word_count_q + 16'd1;
    load_err_d = load_err_q | wr_reject;

    valid_d = valid_q;
    if (wr_accept) valid_d[wr_idx] = 1'b1;

    if_valid_d = rd_fire;
    rd_sel_d   = rd_sel_q;
    if (rd_fire) rd_sel_d = (rd_ok && valid_q[rd_idx]) ? SelRam : SelNop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_sel_q     <= SelZero;
      ready_q      <= 1'b0;
      if_valid_q   <= 1'b0;
      load_err_q   <= 1'b0;
      word_count_q <= 16'd0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_sel_q     <= rd_sel_d;
      ready_q      <= ready_d;
      if_valid_q   <= if_valid_d;
      load_err_q   <= load_err_d;
      word_count_q <= word_count_d;
      valid_q      <= valid_d;
    end
  end

  // Reset-free storage so it maps onto a block RAM; stale words are masked by valid_q.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_idx] <= din;
    if (rd_fire)   rd_data_q     <= mem_q[rd_idx];
  end

  always_comb begin
    if_data = 32'h0;
    unique case (rd_sel_q)
      SelZero: if_data = 32'h0;
      SelNop:  if_data = Nop;
      SelRam:  if_data = rd_data_q;
      default: if_data = 32'h0;
    endcase
  end

  assign if_valid   = if_valid_q;
  assign ready      = ready_q;
  assign start_pc   = RESET_PC;
  assign word_count = word_count_q;
  assign load_err   = load_err_q;

endmodule

// File: doc/instr_mem_sink.md
INSTR_MEM_SINK -- requirements
Module: instr_mem_sink

Interface
REQ-001 Parameter DEPTH, default 256, meaning instruction storage size in 32-bit words (power of two, 4..1024).
REQ-002 Parameter RESET_PC, default 0, meaning byte address of the first fetch after load completes.
REQ-003 Port clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port we  input  1  loader write strobe; a word is offered on every cycle it is high.
REQ-006 Port addr  input  32  loader byte address of the offered word.
REQ-007 Port din  input  32  loader instruction word.
REQ-008 Port if_req  input  1  fetch request from core.
REQ-009 Port if_addr  input  32  fetch byte address.
REQ-010 Port if_data  output  32  fetched instruction word.
REQ-011 Port if_valid  output  1  if_data holds the response to the previous-cycle request.
REQ-012 Port ready  output  1  load complete; core may leave stall and fetch.
REQ-013 Port start_pc  output  32  constant RESET_PC, valid while ready is high.
REQ-014 Port word_count  output  16  number of accepted loader writes since reset.
REQ-015 Port load_err  output  1  sticky flag: a loader write was rejected.

Function
REQ-016 The block SHALL use a three-state FSM: IDLE, LOAD, RUN.
REQ-017 IDLE: we=1 -> LOAD, and that write is processed in the same cycle; we=0 -> stay.
REQ-018 LOAD: we=1 -> stay and process the write; we=0 for exactly one cycle -> RUN (first low cycle ends the load).
REQ-019 RUN is terminal; any we=1 in RUN SHALL be ignored (no storage write, no count change) and SHALL set load_err.
REQ-020 Write acceptance: in IDLE/LOAD, a write is accepted iff addr[1:0]==0 and (addr>>2) < DEPTH; accepted -> mem[addr>>2] <= din, word_count += 1 (saturating at 16'hFFFF).
REQ-021 A rejected write (misaligned or out of range) SHALL not modify storage or word_count and SHALL set load_err.
REQ-022 Repeated writes to the same word are legal; last write wins; each counts once per accepted cycle.
REQ-023 Words never written SHALL read as 32'h00000013 (addi x0,x0,0); the implementation tracks a per-word valid bit cleared at reset.
REQ-024 ready SHALL be high exactly when state==RUN, registered (asserted the cycle after the first we=0 in LOAD).
REQ-025 Fetch: in RUN, if_req=1 at cycle N -> if_valid=1 and if_data = word at if_addr>>2 at cycle N+1 (one-cycle latency, one request per cycle, fully pipelined).
REQ-026 Fetch with if_addr misaligned or out of range SHALL return if_data=32'h00000013 with if_valid=1.
REQ-027 if_req in IDLE or LOAD SHALL be ignored: if_valid=0 next cycle.
REQ-028 if_req=0 -> if_valid=0 next cycle; if_data holds its last value.
REQ-029 The storage SHALL be a single-write/single-read synchronous array, inferable as block RAM plus a DEPTH-bit valid vector.

Reset
REQ-030 While rst=1, outputs SHALL be: if_data=0, if_valid=0, ready=0, word_count=0, load_err=0; state=IDLE; all valid bits cleared.
REQ-031 Storage contents are not cleared by reset; valid bits make stale words read as NOP.
REQ-032 rst asserted mid-LOAD or mid-RUN SHALL abort immediately to IDLE; a following load restarts from word_count=0.

Verification
REQ-033 Load 29 words at addr 0,4,...,112 on consecutive cycles, then we=0 -> ready=1 one cycle after first we=0, word_count=29, load_err=0.
REQ-034 After REQ-033 load, if_req with if_addr=0,4,8 back-to-back -> if_valid=1 on following three cycles with the stored words in order; if_addr=116 -> 32'h00000013.
REQ-035 Write addr=2 then addr=DEPTH*4 during LOAD -> load_err=1, word_count unchanged, memory unmodified.
REQ-036 if_req=1 during LOAD -> if_valid stays 0; we=1 in RUN -> load_err=1, word_count unchanged, stored word unchanged.
REQ-037 Write 32'hAAAA0000 then 32'h5555FFFF to addr 8 -> fetch addr 8 returns 32'h5555FFFF, word_count=2.
REQ-038 Assert rst mid-LOAD after 10 writes -> ready=0, word_count=0, fetch after a new 1-word load at addr 0 returns that word and addr 4 returns 32'h00000013.
